// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the DDR line-port arbiter.
//   IDX_W / LINE_W / MASK_W : DDR line index, line data and byte-mask widths
//   arb_state_e             : arbiter FSM state
//   gnt_side_e              : which requester owns (or last owned) the port
//   arb_ctl_t               : arbiter control state, kept in one struct so the
//                             whole FSM state is visible under a single name
package mem_arb_pkg;

  localparam int IDX_W  = 19;
  localparam int LINE_W = 512;
  localparam int MASK_W = LINE_W / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IFU_BUSY = 2'd1,
    LSU_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_side_e;

  typedef struct packed {
    arb_state_e state;
    gnt_side_e  last_grant;
    logic       killed;
  } arb_ctl_t;

endpackage

// File: rtl/mem_rd_wr_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick between the fetch and load/store sides.
//   last_grant   in  side granted most recently
//   req_ifu      in  fetch side requesting (already qualified by flush)
//   req_lsu      in  load/store side requesting
//   accept       in  caller is able to take a grant this cycle
//   gnt_valid    out at least one side is requesting
//   gnt_side     out side that wins this cycle
//   last_grant_d out next value of the pointer (moves only on an accepted grant)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  gnt_side_e last_grant,
  input  logic      req_ifu,
  input  logic      req_lsu,
  input  logic      accept,
  output logic      gnt_valid,
  output gnt_side_e gnt_side,
  output gnt_side_e last_grant_d
);

  always_comb begin
    gnt_valid = req_ifu | req_lsu;
    if (req_ifu && req_lsu) begin
      // Contention: the side that did not win last time goes first.
      gnt_side = (last_grant == GNT_LSU) ? GNT_IFU : GNT_LSU;
    end else if (req_ifu) begin
      gnt_side = GNT_IFU;
    end else begin
      gnt_side = GNT_LSU;
    end
    last_grant_d = (accept && gnt_valid) ? gnt_side : last_grant;
  end

endmodule

// File: rtl/mem_rd_wr_arbiter.sv
// mem_rd_wr_arbiter: shares one DDR line port between instruction fetch
// (read-only) and load/store (read/write), one transaction at a time.
//   clock, reset_n                : clock, synchronous active-low reset
//   ifu_req_* / ifu_flush         : fetch request and pipeline-flush kill
//   ifu_resp_valid/_data          : one-cycle fetch completion, data held after
//   lsu_req_*                     : load/store request (write, index, data, mask)
//   lsu_resp_valid/_data          : one-cycle completion, read data or 0 for writes
//   ddr_*                         : registered DDR-side request, read data, done
// Handshake: a requester holds valid and payload stable until it sees its
// transaction start (ddr_chip_enable rising with its index); completion is the
// single-cycle *_resp_valid pulse the cycle after ddr_operation_done.
module mem_rd_wr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int IDX_W  = mem_arb_pkg::IDX_W,
  parameter int LINE_W = mem_arb_pkg::LINE_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_req_valid,
  input  logic [IDX_W-1:0]    ifu_req_index,
  input  logic                ifu_flush,
  output logic                ifu_resp_valid,
  output logic [LINE_W-1:0]   ifu_resp_data,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_write,
  input  logic [IDX_W-1:0]    lsu_req_index,
  input  logic [LINE_W-1:0]   lsu_req_wdata,
  input  logic [LINE_W/8-1:0] lsu_req_wmask,
  output logic                lsu_resp_valid,
  output logic [LINE_W-1:0]   lsu_resp_data,
  output logic                ddr_chip_enable,
  output logic                ddr_write_enable,
  output logic [IDX_W-1:0]    ddr_index,
  output logic [LINE_W-1:0]   ddr_write_data,
  output logic [LINE_W/8-1:0] ddr_write_mask,
  input  logic [LINE_W-1:0]   ddr_read_data,
  input  logic                ddr_operation_done
);

  arb_ctl_t              ctl_q, ctl_d;
  logic                  ce_q, ce_d;
  logic                  we_q, we_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W/8-1:0]   wmask_q, wmask_d;
  logic                  ifu_rv_q, ifu_rv_d;
  logic [LINE_W-1:0]     ifu_rd_q, ifu_rd_d;
  logic                  lsu_rv_q, lsu_rv_d;
  logic [LINE_W-1:0]     lsu_rd_q, lsu_rd_d;

  logic      gnt_valid;
  gnt_side_e gnt_side;
  gnt_side_e last_grant_d;

  // A flush in the same cycle as a fetch request withdraws that request.
  rr_arb2 u_rr_arb2 (
    .last_grant   (ctl_q.last_grant),
    .req_ifu      (ifu_req_valid & ~ifu_flush),
    .req_lsu      (lsu_req_valid),
    .accept       (ctl_q.state == IDLE),
    .gnt_valid    (gnt_valid),
    .gnt_side     (gnt_side),
    .last_grant_d (last_grant_d)
  );

  always_comb begin
    ctl_d            = ctl_q;
    ctl_d.last_grant = last_grant_d;
    ce_d             = ce_q;
    we_d             = we_q;
    index_d          = index_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    ifu_rv_d         = 1'b0;
    ifu_rd_d         = ifu_rd_q;
    lsu_rv_d         = 1'b0;
    lsu_rd_d         = lsu_rd_q;

    case (ctl_q.state)
      IDLE: begin
        ctl_d.killed = 1'b0;
        if (gnt_valid) begin
          ce_d = 1'b1;
          if (gnt_side == GNT_IFU) begin
            // Fetches are reads: keep every write-side output at zero.
            we_d        = 1'b0;
            index_d     = ifu_req_index;
            wdata_d     = '0;
            wmask_d     = '0;
            ctl_d.state = IFU_BUSY;
          end else begin
            we_d        = lsu_req_write;
            index_d     = lsu_req_index;
            wdata_d     = lsu_req_wdata;
            wmask_d     = lsu_req_wmask;
            ctl_d.state = LSU_BUSY;
          end
        end
      end
      IFU_BUSY: begin
        if (ddr_operation_done) begin
          ce_d         = 1'b0;
          ctl_d.state  = IDLE;
          ctl_d.killed = 1'b0;
          // A flush landing on the completion cycle kills it as well.
          if (!(ctl_q.killed || ifu_flush)) begin
            ifu_rv_d = 1'b1;
            ifu_rd_d = ddr_read_data;
          end
        end else if (ifu_flush) begin
          // The DDR access runs to completion; only its response is dropped.
          ctl_d.killed = 1'b1;
        end
      end
      LSU_BUSY: begin
        if (ddr_operation_done) begin
          ce_d        = 1'b0;
          we_d        = 1'b0;
          ctl_d.state = IDLE;
          lsu_rv_d    = 1'b1;
          lsu_rd_d    = we_q ? '0 : ddr_read_data;
        end
      end
      default: begin
        ctl_d.state = IDLE;
        ce_d        = 1'b0;
        we_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctl_q.state      <= IDLE;
      ctl_q.last_grant <= GNT_LSU;
      ctl_q.killed     <= 1'b0;
      ce_q             <= 1'b0;
      we_q             <= 1'b0;
      index_q          <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_rv_q         <= 1'b0;
      ifu_rd_q         <= '0;
      lsu_rv_q         <= 1'b0;
      lsu_rd_q         <= '0;
    end else begin
      ctl_q            <= ctl_d;
      ce_q             <= ce_d;
      we_q             <= we_d;
      index_q          <= index_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      ifu_rv_q         <= ifu_rv_d;
      ifu_rd_q         <= ifu_rd_d;
      lsu_rv_q         <= lsu_rv_d;
      lsu_rd_q         <= lsu_rd_d;
    end
  end

  assign ddr_chip_enable  = ce_q;
  assign ddr_write_enable = we_q;
  assign ddr_index        = index_q;
  assign ddr_write_data   = wdata_q;
  assign ddr_write_mask   = wmask_q;
  assign ifu_resp_valid   = ifu_rv_q;
  assign ifu_resp_data    = ifu_rd_q;
  assign lsu_resp_valid   = lsu_rv_q;
  assign lsu_resp_data    = lsu_rd_q;

endmodule

// File: tb/tb_mem_rd_wr_arbiter.sv
// tb_mem_rd_wr_arbiter: directed bench for mem_rd_wr_arbiter. Inputs change
// 1 ns after each rising edge; outputs are checked at that same point.
module tb_mem_rd_wr_arbiter;
  import mem_arb_pkg::*;

  localparam int IW = 19;
  localparam int LW = 512;
  localparam int MW = LW / 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic          ifu_req_valid;
  logic [IW-1:0] ifu_req_index;
  logic          ifu_flush;
  logic          ifu_resp_valid;
  logic [LW-1:0] ifu_resp_data;
  logic          lsu_req_valid;
  logic          lsu_req_write;
  logic [IW-1:0] lsu_req_index;
  logic [LW-1:0] lsu_req_wdata;
  logic [MW-1:0] lsu_req_wmask;
  logic          lsu_resp_valid;
  logic [LW-1:0] lsu_resp_data;
  logic          ddr_chip_enable;
  logic          ddr_write_enable;
  logic [IW-1:0] ddr_index;
  logic [LW-1:0] ddr_write_data;
  logic [MW-1:0] ddr_write_mask;
  logic [LW-1:0] ddr_read_data;
  logic          ddr_operation_done;

  mem_rd_wr_arbiter dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .ifu_req_valid      (ifu_req_valid),
    .ifu_req_index      (ifu_req_index),
    .ifu_flush          (ifu_flush),
    .ifu_resp_valid     (ifu_resp_valid),
    .ifu_resp_data      (ifu_resp_data),
    .lsu_req_valid      (lsu_req_valid),
    .lsu_req_write      (lsu_req_write),
    .lsu_req_index      (lsu_req_index),
    .lsu_req_wdata      (lsu_req_wdata),
    .lsu_req_wmask      (lsu_req_wmask),
    .lsu_resp_valid     (lsu_resp_valid),
    .lsu_resp_data      (lsu_resp_data),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_index          (ddr_index),
    .ddr_write_data     (ddr_write_data),
    .ddr_write_mask     (ddr_write_mask),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid      = 1'b0;
    ifu_req_index      = '0;
    ifu_flush          = 1'b0;
    lsu_req_valid      = 1'b0;
    lsu_req_write      = 1'b0;
    lsu_req_index      = '0;
    lsu_req_wdata      = '0;
    lsu_req_wmask      = '0;
    ddr_read_data      = '0;
    ddr_operation_done = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ce"},       ddr_chip_enable,  '0);
    chk({tag, ".we"},       ddr_write_enable, '0);
    chk({tag, ".index"},    ddr_index,        '0);
    chk({tag, ".wdata"},    ddr_write_data,   '0);
    chk({tag, ".wmask"},    ddr_write_mask,   '0);
    chk({tag, ".ifu_rv"},   ifu_resp_valid,   '0);
    chk({tag, ".ifu_data"}, ifu_resp_data,    '0);
    chk({tag, ".lsu_rv"},   lsu_resp_valid,   '0);
    chk({tag, ".lsu_data"}, lsu_resp_data,    '0);
  endtask

  logic [LW-1:0] line_a5, line_b, line_c, line_d, line_e, line_f, line_g;
  logic [LW-1:0] line_h, line_i, line_m, line_j, line_k, line_l, wdata_1234;
  logic [MW-1:0] mask_lo8;

  initial begin
    line_a5    = {64{8'hA5}};
    line_b     = {16{32'hB0B0_0001}};
    line_c     = {16{32'hC0C0_0002}};
    line_d     = {16{32'hD0D0_0003}};
    line_e     = {16{32'hE0E0_0004}};
    line_f     = {16{32'hF0F0_0005}};
    line_g     = {16{32'h6060_0006}};
    line_h     = {16{32'h7070_0007}};
    line_i     = {16{32'h8080_0008}};
    line_m     = {16{32'h9090_0009}};
    line_j     = {16{32'h3C3C_000A}};
    line_k     = {16{32'h4D4D_000B}};
    line_l     = {16{32'h5E5E_000C}};
    wdata_1234 = {32{16'h1234}};
    mask_lo8   = 64'h0000_0000_0000_00FF;

    // ---- reset state ----
    idle_inputs();
    do_reset();
    chk_all_zero("reset");
    chk("reset.state", dut.ctl_q.state, IDLE);

    // ---- single IFU read, done 3 cycles after enable ----
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00010;
    step();
    chk("ifu1.ce", ddr_chip_enable, 1'b1);
    chk("ifu1.index", ddr_index, 19'h00010);
    chk("ifu1.we", ddr_write_enable, 1'b0);
    ifu_req_valid = 1'b0;
    step();
    step();
    chk("ifu1.ce_hold", ddr_chip_enable, 1'b1);
    chk("ifu1.index_hold", ddr_index, 19'h00010);
    step();
    ddr_operation_done = 1'b1; ddr_read_data = line_a5;
    step();
    ddr_operation_done = 1'b0; ddr_read_data = '0;
    chk("ifu1.ce_off", ddr_chip_enable, 1'b0);
    chk("ifu1.rv", ifu_resp_valid, 1'b1);
    chk("ifu1.data", ifu_resp_data, line_a5);
    chk("ifu1.we_done", ddr_write_enable, 1'b0);
    chk("ifu1.lsu_rv", lsu_resp_valid, 1'b0);
    step();
    chk("ifu1.rv_pulse", ifu_resp_valid, 1'b0);
    chk("ifu1.data_held", ifu_resp_data, line_a5);

    // ---- tie after reset: IFU first, then repeated tie goes to LSU ----
    do_reset();
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00123;
    lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_index = 19'h00456;
    step();
    chk("tie1.ce", ddr_chip_enable, 1'b1);
    chk("tie1.index", ddr_index, 19'h00123);
    ifu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_b;
    step();
    chk("tie1.ifu_rv", ifu_resp_valid, 1'b1);
    chk("tie1.ifu_data", ifu_resp_data, line_b);
    chk("tie1.ce_off", ddr_chip_enable, 1'b0);
    ddr_operation_done = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00789;
    step();
    chk("tie2.ce", ddr_chip_enable, 1'b1);
    chk("tie2.index_lsu", ddr_index, 19'h00456);
    chk("tie2.we", ddr_write_enable, 1'b0);
    lsu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_c;
    step();
    chk("tie2.lsu_rv", lsu_resp_valid, 1'b1);
    chk("tie2.lsu_data", lsu_resp_data, line_c);
    chk("tie2.ifu_rv", ifu_resp_valid, 1'b0);
    ddr_operation_done = 1'b0;
    step();
    chk("tie3.ce", ddr_chip_enable, 1'b1);
    chk("tie3.index_ifu", ddr_index, 19'h00789);
    ifu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_d;
    step();
    chk("tie3.ifu_rv", ifu_resp_valid, 1'b1);
    chk("tie3.ifu_data", ifu_resp_data, line_d);
    ddr_operation_done = 1'b0;

    // ---- LSU write ----
    lsu_req_valid = 1'b1; lsu_req_write = 1'b1; lsu_req_index = 19'h7FFFF;
    lsu_req_wdata = wdata_1234; lsu_req_wmask = mask_lo8;
    step();
    chk("wr.ce", ddr_chip_enable, 1'b1);
    chk("wr.we", ddr_write_enable, 1'b1);
    chk("wr.index", ddr_index, 19'h7FFFF);
    chk("wr.mask", ddr_write_mask, mask_lo8);
    chk("wr.wdata", ddr_write_data, wdata_1234);
    lsu_req_valid = 1'b0; lsu_req_write = 1'b0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    step();
    chk("wr.we_hold", ddr_write_enable, 1'b1);
    ddr_operation_done = 1'b1; ddr_read_data = line_e;
    step();
    chk("wr.lsu_rv", lsu_resp_valid, 1'b1);
    chk("wr.lsu_data_zero", lsu_resp_data, '0);
    chk("wr.ce_off", ddr_chip_enable, 1'b0);
    ddr_operation_done = 1'b0;

    // ---- flush during IFU_BUSY, then LSU granted at D+1 ----
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00AAA;
    step();
    chk("fl.ce", ddr_chip_enable, 1'b1);
    chk("fl.index", ddr_index, 19'h00AAA);
    chk("fl.we_zero", ddr_write_enable, 1'b0);
    chk("fl.wdata_zero", ddr_write_data, '0);
    chk("fl.wmask_zero", ddr_write_mask, '0);
    ifu_req_valid = 1'b0;
    step();
    ifu_flush = 1'b1;
    step();
    ifu_flush = 1'b0;
    chk("fl.killed", dut.ctl_q.killed, 1'b1);
    lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_index = 19'h00BBB;
    step();
    chk("fl.ce_still", ddr_chip_enable, 1'b1);
    chk("fl.index_still", ddr_index, 19'h00AAA);
    ddr_operation_done = 1'b1; ddr_read_data = line_f;
    step();
    chk("fl.ifu_rv_suppressed", ifu_resp_valid, 1'b0);
    chk("fl.ifu_data_held", ifu_resp_data, line_d);
    chk("fl.ce_off", ddr_chip_enable, 1'b0);
    ddr_operation_done = 1'b0;
    step();
    chk("fl.lsu_ce", ddr_chip_enable, 1'b1);
    chk("fl.lsu_index", ddr_index, 19'h00BBB);
    lsu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_g;
    step();
    chk("fl.lsu_rv", lsu_resp_valid, 1'b1);
    chk("fl.lsu_data", lsu_resp_data, line_g);
    ddr_operation_done = 1'b0;

    // ---- flush with IFU request in IDLE, LSU also valid (last grant LSU) ----
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00222; ifu_flush = 1'b1;
    lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_index = 19'h00333;
    step();
    chk("flidle.ce", ddr_chip_enable, 1'b1);
    chk("flidle.index_lsu", ddr_index, 19'h00333);
    chk("flidle.state", dut.ctl_q.state, LSU_BUSY);
    ifu_flush = 1'b0; lsu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_h;
    step();
    chk("flidle.lsu_rv", lsu_resp_valid, 1'b1);
    chk("flidle.lsu_data", lsu_resp_data, line_h);
    ddr_operation_done = 1'b0;
    step();
    chk("flidle.ifu_ce", ddr_chip_enable, 1'b1);
    chk("flidle.ifu_index", ddr_index, 19'h00222);
    ifu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_i;
    step();
    chk("flidle.ifu_rv", ifu_resp_valid, 1'b1);
    chk("flidle.ifu_data", ifu_resp_data, line_i);
    ddr_operation_done = 1'b0;

    // ---- flush coincident with done in IFU_BUSY ----
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00111;
    step();
    chk("fldone.index", ddr_index, 19'h00111);
    ifu_req_valid = 1'b0;
    ifu_flush = 1'b1; ddr_operation_done = 1'b1; ddr_read_data = line_m;
    step();
    chk("fldone.ifu_rv", ifu_resp_valid, 1'b0);
    chk("fldone.ifu_data_held", ifu_resp_data, line_i);
    chk("fldone.ce_off", ddr_chip_enable, 1'b0);
    chk("fldone.killed_clr", dut.ctl_q.killed, 1'b0);
    ifu_flush = 1'b0; ddr_operation_done = 1'b0;

    // ---- reset mid-LSU_BUSY, stray done, then normal IFU ----
    lsu_req_valid = 1'b1; lsu_req_write = 1'b1; lsu_req_index = 19'h00444;
    lsu_req_wdata = line_j; lsu_req_wmask = '1;
    step();
    chk("rst.ce", ddr_chip_enable, 1'b1);
    chk("rst.we", ddr_write_enable, 1'b1);
    lsu_req_valid = 1'b0; lsu_req_write = 1'b0;
    reset_n = 1'b0;
    step();
    chk_all_zero("rst_mid");
    reset_n = 1'b1;
    ddr_operation_done = 1'b1; ddr_read_data = line_k;
    step();
    chk("rst.stray_ce", ddr_chip_enable, 1'b0);
    chk("rst.stray_lsu_rv", lsu_resp_valid, 1'b0);
    chk("rst.stray_ifu_rv", ifu_resp_valid, 1'b0);
    chk("rst.stray_lsu_data", lsu_resp_data, '0);
    ddr_operation_done = 1'b0;
    ifu_req_valid = 1'b1; ifu_req_index = 19'h00555;
    step();
    chk("rst.ifu_ce", ddr_chip_enable, 1'b1);
    chk("rst.ifu_index", ddr_index, 19'h00555);
    chk("rst.ifu_we", ddr_write_enable, 1'b0);
    ifu_req_valid = 1'b0;
    ddr_operation_done = 1'b1; ddr_read_data = line_l;
    step();
    chk("rst.ifu_rv", ifu_resp_valid, 1'b1);
    chk("rst.ifu_data", ifu_resp_data, line_l);
    ddr_operation_done = 1'b0;
    step();
    chk("rst.ifu_rv_pulse", ifu_resp_valid, 1'b0);

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
